// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer borrowing the shared ALU
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result
);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] opnd;
    logic        is_div, neg_q, neg_r;
    logic [4:0]  cnt;
    logic        sgn, div0, carry, borrow, take;
    logic [31:0] m_abs, d_abs, r_sh, m_b;
    logic [63:0] neg64;
    assign sgn    = ~op[0];
    assign div0   = op[1] && rt_data == 32'd0;
    assign m_abs  = (sgn && rs_data[31]) ? -rs_data : rs_data;
    assign d_abs  = (sgn && rt_data[31]) ? -rt_data : rt_data;
    assign r_sh   = {hi[30:0], lo[31]};
    assign m_b    = lo[0] ? opnd : 32'd0;
    assign carry  = (hi[31] & m_b[31]) | ((hi[31] | m_b[31]) & ~alu_result[31]);
    assign borrow = (~r_sh[31] & opnd[31]) | (~(r_sh[31] ^ opnd[31]) & alu_result[31]);
    assign take   = hi[31] | ~borrow;
    assign neg64  = -{hi, lo};
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state and ALU port drive; operands only leave the block during ITER
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = div0 ? DONE : ITER;
            ITER: if (alu_gnt && cnt == 5'd31) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
        busy     = state != IDLE;
        done     = state == DONE;
        alu_req  = state == ITER;
        alu_a    = alu_req ? (is_div ? r_sh : hi) : 32'd0;
        alu_b    = alu_req ? (is_div ? opnd : m_b) : 32'd0;
        alu_ctrl = (alu_req && is_div) ? 4'b0100 : 4'b0000;
    end
    // datapath: operand capture, shift-add / restoring-divide step, sign fixup
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            cnt      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    is_div   <= op[1];
                    neg_q    <= sgn & (rs_data[31] ^ rt_data[31]);
                    neg_r    <= sgn & rs_data[31];
                    div_zero <= div0;
                    cnt      <= '0;
                    hi       <= div0 ? rs_data : 32'd0;
                    lo       <= div0 ? 32'hFFFF_FFFF : (op[1] ? m_abs : d_abs);
                    opnd     <= op[1] ? d_abs : m_abs;
                end
                ITER: if (alu_gnt) begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        hi <= take ? alu_result : r_sh;
                        lo <= {lo[30:0], take};
                    end else begin
                        hi <= {carry, alu_result[31:1]};
                        lo <= {alu_result[0], lo[31:1]};
                    end
                end
                FIX: if (is_div) begin
                    if (neg_q) lo <= -lo;
                    if (neg_r) hi <= -hi;
                end else if (neg_q) begin
                    {hi, lo} <= neg64;
                end
                DONE: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector bench for muldiv_seq with a behavioural shared ALU
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, div_zero, alu_req, alu_gnt;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, hi, lo, alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    int checks = 0;
    int errors = 0;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result)
    );

    assign alu_result = (alu_ctrl == 4'b0100) ? alu_a - alu_b : alu_a + alu_b;

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs, rt, hi, lo;
        logic        dz;
        int          cyc;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // one operation: cycle n is sampled 1 time unit after the n-th edge following the start cycle
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit toggle, input bit poke, output int dcyc, output int zeros,
                       output bit req_seen, output bit hold_bad, output bit busy_bad);
        logic [31:0] ph, pl;
        bit pg, pi;
        int itc;
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1; alu_gnt = 1'b1;
        dcyc = -1; zeros = 0; req_seen = 0; hold_bad = 0; busy_bad = 0;
        itc = 0; pg = 1; pi = 0; ph = hi; pl = lo;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk); #1;
            start = poke && n == 5;
            if (poke && n == 5) begin
                op = 2'b01; rs_data = 32'hDEAD; rt_data = 32'h3;
            end
            if (pi && !pg && (hi !== ph || lo !== pl)) hold_bad = 1;
            if (alu_req) req_seen = 1;
            if (dcyc < 0) begin
                if (!busy) busy_bad = 1;
                if (done) dcyc = n;
            end else begin
                if (busy || done) busy_bad = 1;
                break;
            end
            alu_gnt = 1'b1;
            if (alu_req) begin
                alu_gnt = toggle ? (itc % 2 == 1) : 1'b1;
                itc++;
                if (!alu_gnt) zeros++;
            end
            pg = alu_gnt; pi = alu_req; ph = hi; pl = lo;
        end
        start = 1'b0;
    endtask

    initial begin
        int dcyc, zeros;
        bit req_seen, hold_bad, busy_bad;
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34};
        vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[4]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[6]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
        vecs[7]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34};
        vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vecs[9]  = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, 34};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 34};
        vecs[11] = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
        vecs[12] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
        vecs[13] = '{2'b00, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 1'b0, 34};

        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0; alu_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_dz", {31'd0, div_zero}, 32'd0);
        chk("reset_req", {31'd0, alu_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0, dcyc, zeros, req_seen, hold_bad, busy_bad);
            chk($sformatf("v%0d_done_cycle", i), 32'(dcyc), 32'(vecs[i].cyc));
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("v%0d_div_zero", i), {31'd0, div_zero}, {31'd0, vecs[i].dz});
            chk($sformatf("v%0d_busy_window", i), {31'd0, busy_bad}, 32'd0);
            if (vecs[i].dz) chk($sformatf("v%0d_no_alu_req", i), {31'd0, req_seen}, 32'd0);
        end

        run(2'b01, 32'd7, 32'd9, 1'b1, 1'b0, dcyc, zeros, req_seen, hold_bad, busy_bad);
        chk("stall_zero_cycles", 32'(zeros), 32'd32);
        chk("stall_done_cycle", 32'(dcyc), 32'd66);
        chk("stall_hold", {31'd0, hold_bad}, 32'd0);
        chk("stall_hi", hi, 32'd0);
        chk("stall_lo", lo, 32'd63);

        run(2'b10, 32'd100, 32'd7, 1'b0, 1'b1, dcyc, zeros, req_seen, hold_bad, busy_bad);
        chk("poke_done_cycle", 32'(dcyc), 32'd34);
        chk("poke_hi", hi, 32'd2);
        chk("poke_lo", lo, 32'd14);

        @(negedge clk);
        op = 2'b10; rs_data = 32'hFFFFFFF9; rt_data = 32'd2; start = 1'b1; alu_gnt = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_dz", {31'd0, div_zero}, 32'd0);
        chk("rst_mid_req", {31'd0, alu_req}, 32'd0);
        chk("rst_mid_alu_a", alu_a, 32'd0);
        rst = 1'b0;

        run(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, dcyc, zeros, req_seen, hold_bad, busy_bad);
        chk("after_rst_done_cycle", 32'(dcyc), 32'd34);
        chk("after_rst_hi", hi, 32'hFFFFFFFF);
        chk("after_rst_lo", lo, 32'hFFFFFFFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer for the integer pipeline. It does not contain its own 32-bit adder. It borrows the shared 32-bit ALU through a request/grant port and issues one ADD or SUB per iteration. It produces the 64-bit HI/LO result of MULT, MULTU, DIV and DIVU in 32 granted iterations, followed by a sign-fixup cycle.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation:
  - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  32  multiplicand / dividend.
- `rt_data`  in  32  multiplier / divisor.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid from this cycle.
- `hi`, `lo`  out  32 each  result registers, held until the next accepted start.
  - Multiply: product[63:32] and product[31:0].
  - Divide: remainder and quotient.
- `div_zero`  out  1  set with `done` when a divide has divisor 0; cleared on the next accepted start.
- `alu_req`  out  1  ALU wanted this cycle.
- `alu_gnt`  in  1  ALU granted this cycle.
- `alu_a`, `alu_b`  out  32 each  ALU operands.
- `alu_ctrl`  out  4  ALU control:
  - 4'b0000 ADD, 4'b0100 SUB.
- `alu_result`  in  32  combinational ALU result for the current operands.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE, `start`=1:
  - Capture the operation type. For signed ops, replace each operand with its magnitude (internal negate): M = |rs|, D = |rt|.
  - Record `neg_q` = rs[31]^rt[31] and `neg_r` = rs[31]. Both are 0 for unsigned ops.
  - Clear `div_zero` and load the iteration counter with 0.
  - Multiply: hi=0, lo=D (multiplier), mcand=M. Divide: hi=0, lo=M (dividend), D = divisor.
  - Divide with `rt_data`==0: go straight to DONE with hi=rs_data, lo=32'hFFFFFFFF, `div_zero`=1.
  - Otherwise go to ITER.
- ITER: `alu_req`=1. An iteration commits only on a cycle with `alu_gnt`=1; with `alu_gnt`=0 all registers and the counter hold.
- Multiply iteration:
  - ALU inputs: alu_a=hi, alu_b = lo[0] ? mcand : 0, ADD.
  - Carry is computed locally: c = (hi[31]&b[31]) | ((hi[31]|b[31]) & ~alu_result[31]).
  - Update: {hi,lo} <= {c, alu_result, lo[31:1]}.
- Divide iteration (restoring):
  - Shift: R' = {hi[30:0], lo[31]}, with shifted-out bit s = hi[31].
  - ALU inputs: alu_a=R', alu_b=D, SUB.
  - Borrow: bw = (~R'[31]&D[31]) | (~(R'[31]^D[31]) & alu_result[31]).
  - If s | ~bw: hi<=alu_result, lo<={lo[30:0],1}. Else: hi<=R', lo<={lo[30:0],0}.
- After the 32nd granted iteration go to FIX.
- FIX: one cycle, no ALU use.
  - Multiply with neg_q: {hi,lo} <= two's-complement negate of the 64-bit value.
  - Divide: lo negated if neg_q; hi negated if neg_r.
  - Then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- Outside ITER: `alu_req`=0, alu_a=0, alu_b=0, alu_ctrl=4'b0000.
- -2^31 / -1 is not flagged: lo=32'h80000000, hi=0 (wraps naturally).

## Timing
- Reset (synchronous, any state including mid-ITER), effective on the next edge:
  - state=IDLE.
  - hi=0, lo=0, div_zero=0, done=0, busy=0, alu_req=0; counter 0.
- Let cycle 0 be the IDLE cycle with start=1. With `alu_gnt` tied high:
  - ITER in cycles 1–32.
  - FIX in cycle 33.
  - DONE in cycle 34 (`done`=1).
  - busy is high in cycles 1–34.
- Each cycle of `alu_gnt`=0 during ITER adds exactly one cycle of latency.
- Divide by zero: DONE in cycle 1; busy is high in cycle 1 only.
- A new start is accepted at the earliest in cycle 35 (the first cycle back in IDLE).
- `alu_a`, `alu_b` and `alu_ctrl` are combinational from registered state. `alu_result` must settle within the same cycle; there is no ALU pipeline stage.

## Test plan
- MULTU, rs=rt=32'hFFFFFFFF, gnt=1: hi=32'hFFFFFFFE, lo=32'h00000001; done in cycle 34, busy in cycles 1–34.
- MULT, rs=-3, rt=5: hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. MULT, rs=32'h80000000, rt=32'h80000000: hi=32'h40000000, lo=0.
- DIV, rs=-7, rt=2: lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU, rs=32'hFFFFFFFF, rt=32'h10: lo=32'h0FFFFFFF, hi=32'hF. DIV, rs=32'h80000000, rt=-1: lo=32'h80000000, hi=0.
- DIVU, rs=32'h1234, rt=0: done in cycle 1, div_zero=1, hi=32'h1234, lo=32'hFFFFFFFF, alu_req never high. The next normal op clears div_zero.
- MULTU 7*9 with alu_gnt toggling 1,0,1,0,...: result hi=0, lo=63. done lands exactly 32 cycles later than with gnt=1; registers hold on gnt=0 cycles.
- rst at cycle 10 of a divide: the next cycle shows IDLE with all outputs 0. start=1 during busy is ignored, and a start after reset yields the correct result.
